// File: rtl/sprite_layer.sv
// sprite_layer: composites one 16x16 keyed sprite over a flat background.
// It works one pixel ahead of the VGA timing generator. Position updates
// are buffered and applied only at the frame boundary, so a frame never
// shows two sprite positions.
module sprite_layer #(
  parameter int          H_ACTIVE  = 800,
  parameter int          V_ACTIVE  = 600,
  parameter logic [5:0]  BG_COLOR  = 6'b000001,
  parameter logic [5:0]  KEY_COLOR = 6'b110011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] nextH,
  input  logic [9:0]  nextV,
  input  logic        nextActive,
  output logic [5:0]  pixel,
  input  logic [10:0] pos_x,
  input  logic [9:0]  pos_y,
  input  logic        pos_valid,
  output logic        pos_ready,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [5:0]  wr_data,
  output logic        frame_start
);

  logic [10:0] cur_x, pend_x;
  logic [9:0]  cur_y, pend_y;
  logic        pend_flag;
  logic        bnd_d;
  logic        bnd, frame_edge, xfer, hit;
  logic [11:0] h_ext, v_ext, cx_ext, cy_ext;
  logic [3:0]  col, row;
  logic [5:0]  texel;
  logic [5:0]  mem [256];

  // Picks the output colour for one position; blanking is always black.
  function automatic logic [5:0] compose(input logic active, input logic in_sprite,
                                         input logic [5:0] tex);
    if (!active)
      return 6'd0;
    else if (in_sprite && tex != KEY_COLOR)
      return tex;
    else
      return BG_COLOR;
  endfunction

  // The boundary is the first blanking position after the last visible line.
  // The edge detect keeps a stalled generator from firing the event twice.
  assign bnd        = (nextH == 11'd0) && (nextV == 10'(V_ACTIVE));
  assign frame_edge = bnd && !bnd_d;
  assign pos_ready  = !pend_flag;
  assign xfer       = pos_valid && pos_ready;

  // Widen to 12 bits so cur+16 near the right and bottom edges clips instead of wrapping.
  assign h_ext  = {1'b0, nextH};
  assign v_ext  = {2'b0, nextV};
  assign cx_ext = {1'b0, cur_x};
  assign cy_ext = {2'b0, cur_y};
  assign hit    = nextActive &&
                  (h_ext >= cx_ext) && (h_ext < cx_ext + 12'd16) &&
                  (v_ext >= cy_ext) && (v_ext < cy_ext + 12'd16);

  // Only the low four bits of the offset address the 16x16 texel grid.
  assign col   = nextH[3:0] - cur_x[3:0];
  assign row   = nextV[3:0] - cur_y[3:0];
  assign texel = mem[{row, col}];

  // Sprite memory write port; it is not reset, so texels survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  // Capture the requested position whenever the buffer accepts it.
  always_ff @(posedge clk) begin
    if (xfer) begin
      pend_x <= pos_x;
      pend_y <= pos_y;
    end
  end

  // Frame-boundary control: edge delay, pulse, pending flag and live position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bnd_d       <= 1'b0;
      frame_start <= 1'b0;
      pend_flag   <= 1'b0;
      cur_x       <= 11'(H_ACTIVE);
      cur_y       <= 10'd0;
    end else begin
      bnd_d       <= bnd;
      frame_start <= frame_edge;
      if (frame_edge && pend_flag) begin
        cur_x <= pend_x;
        cur_y <= pend_y;
      end
      // A request arriving on the edge clock waits for the next boundary.
      if (xfer)
        pend_flag <= 1'b1;
      else if (frame_edge)
        pend_flag <= 1'b0;
    end
  end

  // Output pixel register: one clock behind the look-ahead coordinates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pixel <= 6'd0;
    else
      pixel <= compose(nextActive, hit, texel);
  end

endmodule
